// File: rtl/tow_match_keeper_pkg.sv
// Shared types and 7-seg constants for the tug-of-war match keeper.
// All segment patterns are active-low, bit order {g,f,e,d,c,b,a}.
package tow_pkg;

  typedef enum logic [2:0] {
    PLAY,
    HOLD,
    CLEAR,
    WAIT_OFF,
    DONE
  } match_state_e;

  localparam logic [6:0] SEG_OFF = 7'b1111111;

  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'b1000000,  // 0
    7'b1111001,  // 1
    7'b0100100,  // 2
    7'b0110000,  // 3
    7'b0011001,  // 4
    7'b0010010,  // 5
    7'b0000010,  // 6
    7'b1111000,  // 7
    7'b0000000,  // 8
    7'b0010000   // 9
  };

  // The winner latch shows the winning player's number as a digit.
  localparam logic [6:0] P1_CODE_DEF = 7'b1111001;
  localparam logic [6:0] P2_CODE_DEF = 7'b0100100;

endpackage

// File: rtl/tow_match_keeper_if.sv
// Bundle between the winner latch / HEX display side and the match keeper.
// master = latch/display side, slave = tow_match_keeper.
interface tow_match_keeper_if;
  logic [6:0] win_code;
  logic       round_reset;
  logic [6:0] score1_seg;
  logic [6:0] score2_seg;
  logic [6:0] winner_seg;
  logic       match_over;
  logic       code_err;

  modport master (
    output win_code,
    input  round_reset, score1_seg, score2_seg, winner_seg, match_over, code_err
  );

  modport slave (
    input  win_code,
    output round_reset, score1_seg, score2_seg, winner_seg, match_over, code_err
  );
endinterface

// File: rtl/tow_match_keeper_seg7.sv
// Combinational 4-bit value to active-low 7-seg digit; values above 9 blank the digit.
module seg7_digit
  import tow_pkg::*;
(
  input  logic [3:0] value,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_OFF;
    if (value <= 4'd9) begin
      seg = SEG_DIGIT[value];
    end
  end

endmodule

// File: rtl/tow_match_keeper.sv
// Tracks round wins from the winner-latch code, holds each result, pulses round_reset
// and declares the match winner once a player reaches WINS_TO_MATCH rounds.
module tow_match_keeper
  import tow_pkg::*;
#(
  parameter logic [6:0] P1_CODE       = P1_CODE_DEF,
  parameter logic [6:0] P2_CODE       = P2_CODE_DEF,
  parameter logic [6:0] OFF_CODE      = SEG_OFF,
  parameter int         WINS_TO_MATCH = 3,
  parameter int         HOLD_CYCLES   = 8
) (
  input  logic              clk,
  input  logic              reset,
  tow_match_keeper_if.slave bus
);

  localparam int SW = $clog2(WINS_TO_MATCH + 1);
  localparam int CW = $clog2(HOLD_CYCLES + 1);
  localparam logic [SW-1:0] WINS      = SW'(WINS_TO_MATCH);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);

  match_state_e  state_reg;
  logic [SW-1:0] score_reg [2];
  logic [CW-1:0] count_reg;
  logic          code_err_reg;
  logic [6:0]    score_seg [2];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= PLAY;
      score_reg[0] <= '0;
      score_reg[1] <= '0;
      count_reg    <= '0;
      code_err_reg <= 1'b0;
    end else begin
      case (state_reg)
        PLAY: begin
          if (bus.win_code == P1_CODE) begin
            score_reg[0] <= score_reg[0] + SW'(1);
            count_reg    <= HOLD_LAST;
            state_reg    <= HOLD;
          end else if (bus.win_code == P2_CODE) begin
            score_reg[1] <= score_reg[1] + SW'(1);
            count_reg    <= HOLD_LAST;
            state_reg    <= HOLD;
          end else if (bus.win_code != OFF_CODE) begin
            code_err_reg <= 1'b1;
          end
        end
        HOLD: begin
          if (count_reg == '0) begin
            state_reg <= CLEAR;
          end else begin
            count_reg <= count_reg - CW'(1);
          end
        end
        CLEAR: begin
          state_reg <= ((score_reg[0] == WINS) || (score_reg[1] == WINS)) ? DONE : WAIT_OFF;
        end
        // A latch code still showing the last winner must not score again.
        WAIT_OFF: begin
          if (bus.win_code == OFF_CODE) begin
            state_reg <= PLAY;
          end
        end
        DONE: begin
          state_reg <= DONE;
        end
        default: begin
          state_reg <= PLAY;
        end
      endcase
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_score_digit
    seg7_digit u_digit (
      .value (4'(score_reg[gi])),
      .seg   (score_seg[gi])
    );
  end

  // Outputs decode only from registered state so reset clears them immediately.
  assign bus.round_reset = (state_reg == CLEAR) || (state_reg == DONE);
  assign bus.match_over  = (state_reg == DONE);
  assign bus.code_err    = code_err_reg;
  assign bus.score1_seg  = score_seg[0];
  assign bus.score2_seg  = score_seg[1];
  assign bus.winner_seg  = (state_reg != DONE)      ? OFF_CODE :
                           (score_reg[0] == WINS)   ? P1_CODE  : P2_CODE;

endmodule
